ipsxe_floating_point_fl2fx_pipe_v1_0: RTL and testbench

- Pipelined floating-point to signed fixed-point converter (fl2fx path).
- Accepts one IEEE-754-style float per beat and outputs a two's-complement fixed-point word.
- Unpacks and classifies the input, aligns the mantissa with a barrel shifter, applies round-to-nearest-even on the discarded bits, then negates and saturates.
- Stream valid/ready handshake on both sides. Full backpressure support.

---
 rtl/ipsxe_floating_point_fl2fx_pipe_v1_0.sv | 162 ++++++++++++++++
 tb/tb_ipsxe_floating_point_fl2fx_pipe_v1_0.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipsxe_floating_point_fl2fx_pipe_v1_0.sv
// Three-stage float to signed fixed-point converter with round-to-nearest-even,
// saturation and a single global stall enable shared by all stages.
module ipsxe_floating_point_fl2fx_pipe_v1_0 #(
  parameter int FLOAT_EXP_BIT  = 8,
  parameter int FLOAT_FRAC_BIT = 24,
  parameter int FIX_INT_BIT    = 16,
  parameter int FIX_FRAC_BIT   = 16
) (
  input  logic                                    i_aclk,
  input  logic                                    i_aresetn,
  input  logic [FLOAT_EXP_BIT+FLOAT_FRAC_BIT-1:0] i_tdata,
  input  logic                                    i_tvalid,
  output logic                                    o_tready,
  output logic [FIX_INT_BIT+FIX_FRAC_BIT-1:0]     o_tdata,
  output logic                                    o_tvalid,
  input  logic                                    i_tready,
  output logic                                    o_overflow,
  output logic                                    o_invalid
);

  localparam int E      = FLOAT_EXP_BIT;
  localparam int F      = FLOAT_FRAC_BIT;
  localparam int W      = FIX_INT_BIT + FIX_FRAC_BIT;
  localparam int BIAS   = 2**(E-1) - 1;
  localparam int SH_OFS = BIAS - FIX_FRAC_BIT + F - 1;
  localparam int SH_W   = E + $clog2(W + F) + 2;
  localparam int DW     = W + F;
  localparam logic [F-1:0] HALF = {1'b1, {(F-1){1'b0}}};

  function automatic logic rnd_up(input logic [F-1:0] fld, input logic lsb);
    return (fld > HALF) || ((fld == HALF) && lsb);
  endfunction

  function automatic logic [W-1:0] sat_val(input logic neg);
    return neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  endfunction

  logic ce;
  logic vld_p0, vld_p1, vld_p2;

  assign ce       = ~vld_p2 | i_tready;
  assign o_tready = ce;
  assign o_tvalid = vld_p2;

  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else if (ce) begin
      vld_p0 <= i_tvalid;
      vld_p1 <= vld_p0;
    end
  end

  // Stage 0: unpack, classify, compute signed alignment shift
  logic [E-1:0]           exp_in;
  logic [F-2:0]           frac_in;
  logic signed [SH_W-1:0] sh_c;

  assign exp_in  = i_tdata[E+F-2:F-1];
  assign frac_in = i_tdata[F-2:0];
  assign sh_c    = $signed({{(SH_W-E){1'b0}}, exp_in}) - $signed(SH_W'(SH_OFS));

  logic                   sign_p0, zero_p0, nan_p0, inf_p0;
  logic [F-1:0]           mant_p0;
  logic signed [SH_W-1:0] sh_p0;

  always_ff @(posedge i_aclk) begin
    if (ce) begin
      sign_p0 <= i_tdata[E+F-1];
      mant_p0 <= {|exp_in, frac_in};
      sh_p0   <= sh_c;
      zero_p0 <= (exp_in == '0);
      nan_p0  <= (&exp_in) & (|frac_in);
      inf_p0  <= (&exp_in) & ~(|frac_in);
    end
  end

  // Stage 1: barrel-shift alignment, range check, capture discarded field
  logic [DW-1:0]   shl;
  logic [2*F-1:0]  shr;
  logic [F:0]      hi;
  logic [SH_W-1:0] shu, rsh;
  logic [W:0]      mag_c;
  logic [F-1:0]    fld_c;
  logic            ovf_c;

  always_comb begin
    shl   = '0;
    shr   = '0;
    hi    = '0;
    shu   = sh_p0;
    rsh   = -shu;
    mag_c = '0;
    fld_c = '0;
    ovf_c = 1'b0;
    if (!(zero_p0 | nan_p0 | inf_p0)) begin
      if (!sh_p0[SH_W-1]) begin
        if (sh_p0 >= $signed(SH_W'(W))) begin
          ovf_c = 1'b1;
        end else begin
          shl   = DW'(mant_p0) << shu;
          hi    = shl[DW-1:W-1];
          // A magnitude of exactly 2^(W-1) is still representable when negative
          ovf_c = (hi != '0) && !(sign_p0 && (hi == (F+1)'(1)) && (shl[W-2:0] == '0));
          mag_c = shl[W:0];
        end
      end else if (rsh <= SH_W'(F)) begin
        shr   = {mant_p0, {F{1'b0}}} >> rsh;
        mag_c = (W+1)'(shr[2*F-1:F]);
        fld_c = shr[F-1:0];
      end
    end
  end

  logic [W:0]   mag_p1;
  logic [F-1:0] fld_p1;
  logic         sign_p1, ovf_p1, nan_p1, inf_p1;

  always_ff @(posedge i_aclk) begin
    if (ce) begin
      mag_p1  <= mag_c;
      fld_p1  <= fld_c;
      sign_p1 <= sign_p0;
      ovf_p1  <= ovf_c;
      nan_p1  <= nan_p0;
      inf_p1  <= inf_p0;
    end
  end

  // Stage 2: round, detect rounding-carry overflow, negate and saturate
  logic [W:0]          sum_c;
  logic                big_c, sat_c;
  logic signed [W-1:0] res_c;

  always_comb begin
    sum_c = mag_p1 + {{W{1'b0}}, rnd_up(fld_p1, mag_p1[0])};
    big_c = sum_c[W] | (sum_c[W-1] & ~(sign_p1 & (sum_c[W-2:0] == '0)));
    sat_c = ovf_p1 | inf_p1 | big_c;
    res_c = sign_p1 ? -signed'(sum_c[W-1:0]) : signed'(sum_c[W-1:0]);
    if (nan_p1) begin
      res_c = signed'(sat_val(1'b0));
    end else if (sat_c) begin
      res_c = signed'(sat_val(sign_p1));
    end
  end

  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      vld_p2     <= 1'b0;
      o_tdata    <= '0;
      o_overflow <= 1'b0;
      o_invalid  <= 1'b0;
    end else if (ce) begin
      vld_p2     <= vld_p1;
      o_tdata    <= res_c;
      o_overflow <= sat_c & ~nan_p1;
      o_invalid  <= nan_p1;
    end
  end

endmodule

// File: tb/tb_ipsxe_floating_point_fl2fx_pipe_v1_0.sv
// Bench for the float32 -> Q16.16 converter: a real-arithmetic reference model
// drives expectations for directed, random, backpressured and reset scenarios.
module tb_ipsxe_floating_point_fl2fx_pipe_v1_0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic        out_ready;
  logic        o_tready;
  logic [31:0] o_tdata;
  logic        o_tvalid;
  logic        o_overflow;
  logic        o_invalid;

  always #5 clk = ~clk;

  ipsxe_floating_point_fl2fx_pipe_v1_0 #(
    .FLOAT_EXP_BIT (8),
    .FLOAT_FRAC_BIT(24),
    .FIX_INT_BIT   (16),
    .FIX_FRAC_BIT  (16)
  ) dut (
    .i_aclk    (clk),
    .i_aresetn (rst_n),
    .i_tdata   (in_data),
    .i_tvalid  (in_valid),
    .o_tready  (o_tready),
    .o_tdata   (o_tdata),
    .o_tvalid  (o_tvalid),
    .i_tready  (out_ready),
    .o_overflow(o_overflow),
    .o_invalid (o_invalid)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        ovf;
    logic        inv;
  } exp_t;

  exp_t        exp_q[$];
  int          stamp_q[$];
  logic [31:0] vec[$];
  int          errors = 0;
  int          checks = 0;

  // Value-level model: scale the float by 2^16 as a real number, round half to
  // even on the magnitude, then clamp to the signed 32-bit range.
  function automatic exp_t model(input logic [31:0] f);
    exp_t   r;
    logic   s;
    int     e;
    longint m, mag, lim;
    real    x, fl;
    r = '0;
    s = f[31];
    e = int'(f[30:23]);
    m = longint'({1'b1, f[22:0]});
    if (e == 255) begin
      if (f[22:0] != 0) begin
        r.d   = 32'h7FFF_FFFF;
        r.inv = 1'b1;
      end else begin
        r.d   = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
        r.ovf = 1'b1;
      end
      return r;
    end
    if (e == 0) return r;
    x = real'(m) * (2.0 ** real'(e - 150)) * 65536.0;
    if (x >= 4294967296.0) begin
      mag = 64'sd4294967296;
    end else begin
      fl  = $floor(x);
      mag = longint'(fl);
      if ((x - fl > 0.5) || ((x - fl == 0.5) && mag[0])) mag = mag + 1;
    end
    lim = s ? 64'sd2147483648 : 64'sd2147483647;
    if (mag > lim) begin
      r.d   = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
      r.ovf = 1'b1;
    end else begin
      r.d = s ? 32'(-mag) : 32'(mag);
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_float();
    logic [7:0] e;
    int sel;
    sel = $urandom_range(0, 19);
    if (sel == 0)      e = 8'h00;
    else if (sel == 1) e = 8'hFF;
    else               e = 8'($urandom_range(100, 145));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  task automatic test_reset;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_tvalid, o_tdata, o_overflow, o_invalid} !== 35'd0)
      begin errors++; $display("FAIL reset_outputs got vld=%b data=%h ovf=%b inv=%b expected all 0",
                                o_tvalid, o_tdata, o_overflow, o_invalid); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (o_tready !== 1'b1 || o_tvalid !== 1'b0)
      begin errors++; $display("FAIL reset_release got tready=%b tvalid=%b expected 1/0", o_tready, o_tvalid); end
  endtask

  // Directed corner values plus random floats, downstream always ready:
  // every result must match the model and arrive exactly 3 cycles after acceptance.
  task automatic test_values;
    int   idx, cyc, lat;
    exp_t e;
    vec.delete();
    exp_q.delete();
    stamp_q.delete();
    vec = '{32'h3FC0_0000, 32'hBF80_0000, 32'h3700_0000, 32'h37C0_0000, 32'h3700_0001,
            32'hB7C0_0000, 32'h471C_4000, 32'hC700_0000, 32'h46FF_FFFF, 32'h7FC0_0000,
            32'hFF80_0000, 32'h0000_0001, 32'h8000_0000, 32'h7F80_0000, 32'hC700_0001,
            32'h4700_0000, 32'h3F00_0000};
    for (int i = 0; i < 40; i++) vec.push_back(rand_float());
    idx = 0;
    cyc = 0;
    while ((idx < vec.size() || exp_q.size() != 0) && cyc < 500) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (idx < vec.size());
      if (in_valid) in_data = vec[idx];
      #1;
      if (o_tvalid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL values_spurious got data=%h expected no beat", o_tdata);
        end else begin
          e = exp_q.pop_front();
          if ({o_tdata, o_overflow, o_invalid} !== {e.d, e.ovf, e.inv}) begin
            errors++;
            $display("FAIL values_data got %h ovf=%b inv=%b expected %h ovf=%b inv=%b",
                     o_tdata, o_overflow, o_invalid, e.d, e.ovf, e.inv);
          end
          lat = cyc - stamp_q.pop_front();
          checks++;
          if (lat != 3) begin errors++; $display("FAIL values_latency got %0d expected 3", lat); end
        end
      end
      if (in_valid && o_tready) begin
        exp_q.push_back(model(in_data));
        stamp_q.push_back(cyc);
        idx++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    if (cyc >= 500) begin checks++; errors++; $display("FAIL values_timeout got %0d cycles expected < 500", cyc); end
  endtask

  // Random backpressure: order preserved, no loss/duplication, output held
  // while stalled, and the ready output follows the global enable rule.
  task automatic test_back_to_back;
    int   idx, cyc, n;
    exp_t e;
    vec.delete();
    exp_q.delete();
    n = 24;
    for (int i = 0; i < n; i++) vec.push_back(rand_float());
    idx = 0;
    cyc = 0;
    while ((idx < n || exp_q.size() != 0) && cyc < 1000) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (idx < n);
      if (in_valid) in_data = vec[idx];
      #1;
      checks++;
      if (o_tready !== (~o_tvalid | out_ready))
        begin errors++; $display("FAIL b2b_tready got %b expected %b", o_tready, ~o_tvalid | out_ready); end
      if (o_tvalid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_spurious got data=%h expected no beat", o_tdata);
        end else begin
          e = exp_q[0];
          if ({o_tdata, o_overflow, o_invalid} !== {e.d, e.ovf, e.inv}) begin
            errors++;
            $display("FAIL b2b_data got %h ovf=%b inv=%b expected %h ovf=%b inv=%b",
                     o_tdata, o_overflow, o_invalid, e.d, e.ovf, e.inv);
          end
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && o_tready) begin
        exp_q.push_back(model(in_data));
        idx++;
      end
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (cyc >= 1000) begin checks++; errors++; $display("FAIL b2b_timeout got %0d cycles expected < 1000", cyc); end
  endtask

  task automatic test_reset_midflight;
    int   cyc;
    logic seen;
    exp_t e;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 32'h3F80_0000 + 32'(k << 20);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (o_tvalid !== 1'b1) begin errors++; $display("FAIL midreset_inflight got tvalid=%b expected 1", o_tvalid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_tvalid, o_tdata, o_overflow, o_invalid} !== 35'd0)
      begin errors++; $display("FAIL midreset_async got vld=%b data=%h expected 0/0", o_tvalid, o_tdata); end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    seen      = 1'b0;
    repeat (8) begin
      @(negedge clk);
      #1;
      if (o_tvalid) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL midreset_stale got a beat after release expected none"); end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'hC0A0_0000;
    e        = model(in_data);
    cyc      = 0;
    seen     = 1'b0;
    while (!seen && cyc < 10) begin
      @(negedge clk);
      in_valid = 1'b0;
      cyc++;
      #1;
      seen = o_tvalid;
    end
    checks++;
    if (!seen || cyc != 3)
      begin errors++; $display("FAIL midreset_latency got seen=%b cycles=%0d expected 3", seen, cyc); end
    checks++;
    if ({o_tdata, o_overflow, o_invalid} !== {e.d, e.ovf, e.inv})
      begin errors++; $display("FAIL midreset_data got %h expected %h", o_tdata, e.d); end
  endtask

  initial begin
    test_reset();
    test_values();
    test_back_to_back();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
